tt_um_jleugeri_ticktocktokens_progloader: RTL and testbench

TT_UM_JLEUGERI_TICKTOCKTOKENS_PROGLOADER -- requirements
Module: tt_um_jleugeri_ticktocktokens_progloader

---
 rtl/tt_um_jleugeri_ticktocktokens_progloader.sv | 167 ++++++++++++++++
 tb/tb_tt_um_jleugeri_ticktocktokens_progloader.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_jleugeri_ticktocktokens_progloader.sv
// rtl/tt_um_jleugeri_ticktocktokens_progloader.sv - byte-stream program loader issuing table writes to the main core
// Optional address auto-increment after each completed write: define PROGLOADER_AUTOINC_EN.
module tt_um_jleugeri_ticktocktokens_progloader #(
  parameter int NUM_PROCESSORS  = 10,
  parameter int NUM_CONNECTIONS = 50,
  parameter int PROG_HEADER     = 4,
  parameter int PROG_BITS       = 8
) (
  input  logic                   clock_fast,
  input  logic                   reset,
  input  logic [PROG_HEADER-1:0] prog_header,
  input  logic [PROG_BITS-1:0]   prog_data,
  input  logic                   prog_strobe,
  output logic                   wr_valid,
  input  logic                   wr_ready,
  output logic [PROG_HEADER-1:0] wr_field,
  output logic [PROG_BITS-1:0]   wr_addr,
  output logic [2*PROG_BITS-1:0] wr_data,
  output logic                   prog_error
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WAIT_HI = 2'd1;
  localparam logic [1:0] S_EMIT    = 2'd2;

  localparam logic [PROG_HEADER-1:0] H_NOP      = PROG_HEADER'(0);
  localparam logic [PROG_HEADER-1:0] H_SET_ADDR = PROG_HEADER'(1);
  localparam logic [PROG_HEADER-1:0] H_P0       = PROG_HEADER'(2);
  localparam logic [PROG_HEADER-1:0] H_P1       = PROG_HEADER'(3);
  localparam logic [PROG_HEADER-1:0] H_P2       = PROG_HEADER'(4);
  localparam logic [PROG_HEADER-1:0] H_C0       = PROG_HEADER'(5);
  localparam logic [PROG_HEADER-1:0] H_C1       = PROG_HEADER'(6);
  localparam logic [PROG_HEADER-1:0] H_DUR      = PROG_HEADER'(8);
  localparam logic [PROG_HEADER-1:0] H_ABORT    = PROG_HEADER'(15);

  logic [1:0]             r_state,  w_state;
  logic                   r_strobe_q;
  logic [PROG_BITS-1:0]   r_addr,   w_addr;
  logic [PROG_BITS-1:0]   r_lo,     w_lo;
  logic                   r_valid,  w_valid;
  logic [PROG_HEADER-1:0] r_field,  w_field;
  logic [PROG_BITS-1:0]   r_waddr,  w_waddr;
  logic [2*PROG_BITS-1:0] r_wdata,  w_wdata;
  logic                   r_error,  w_error;

  logic w_accept;
  logic w_proc_ok;
  logic w_conn_ok;

  assign w_accept  = prog_strobe & ~r_strobe_q;
  assign w_proc_ok = int'(r_addr) < NUM_PROCESSORS;
  assign w_conn_ok = int'(r_addr) < NUM_CONNECTIONS;

  assign wr_valid   = r_valid;
  assign wr_field   = r_field;
  assign wr_addr    = r_waddr;
  assign wr_data    = r_wdata;
  assign prog_error = r_error;

  always_comb begin
    w_state = r_state;
    w_addr  = r_addr;
    w_lo    = r_lo;
    w_valid = r_valid;
    w_field = r_field;
    w_waddr = r_waddr;
    w_wdata = r_wdata;
    w_error = r_error;

    if (r_valid && wr_ready) begin
      w_valid = 1'b0;
      w_state = S_IDLE;
`ifdef PROGLOADER_AUTOINC_EN
      w_addr  = r_addr + 1'b1;
`endif
    end

    if (w_accept) begin
      if (prog_header == H_ABORT) begin
        w_state = S_IDLE;
        w_addr  = '0;
        w_lo    = '0;
        w_valid = 1'b0;
        w_error = 1'b0;
      end else if (r_state == S_EMIT) begin
        // The pending command owns the output registers; anything arriving now is lost.
        w_error = 1'b1;
      end else if (r_state == S_WAIT_HI && prog_header == H_DUR) begin
        w_lo = '0;
        if (w_proc_ok) begin
          w_state = S_EMIT;
          w_valid = 1'b1;
          w_field = prog_header;
          w_waddr = r_addr;
          w_wdata = {prog_data, r_lo};
        end else begin
          w_error = 1'b1;
          w_state = S_IDLE;
        end
      end else begin
        // A foreign header inside a duration pair abandons the pair, then runs as a fresh byte.
        if (r_state == S_WAIT_HI) begin
          w_error = 1'b1;
          w_lo    = '0;
          w_state = S_IDLE;
        end
        case (prog_header)
          H_NOP: begin
          end
          H_SET_ADDR: w_addr = prog_data;
          H_P0, H_P1, H_P2: begin
            if (w_proc_ok) begin
              w_state = S_EMIT;
              w_valid = 1'b1;
              w_field = prog_header;
              w_waddr = r_addr;
              w_wdata = {{PROG_BITS{1'b0}}, prog_data};
            end else begin
              w_error = 1'b1;
            end
          end
          H_C0, H_C1: begin
            if (w_conn_ok) begin
              w_state = S_EMIT;
              w_valid = 1'b1;
              w_field = prog_header;
              w_waddr = r_addr;
              w_wdata = {{PROG_BITS{1'b0}}, prog_data};
            end else begin
              w_error = 1'b1;
            end
          end
          H_DUR: begin
            w_lo    = prog_data;
            w_state = S_WAIT_HI;
          end
          default: w_error = 1'b1;
        endcase
      end
    end
  end

  always_ff @(posedge clock_fast) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_strobe_q <= 1'b1;
      r_addr     <= '0;
      r_lo       <= '0;
      r_valid    <= 1'b0;
      r_field    <= '0;
      r_waddr    <= '0;
      r_wdata    <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_strobe_q <= prog_strobe;
      r_addr     <= w_addr;
      r_lo       <= w_lo;
      r_valid    <= w_valid;
      r_field    <= w_field;
      r_waddr    <= w_waddr;
      r_wdata    <= w_wdata;
      r_error    <= w_error;
    end
  end

endmodule

// File: tb/tb_tt_um_jleugeri_ticktocktokens_progloader.sv
// tb/tb_tt_um_jleugeri_ticktocktokens_progloader.sv - directed vector bench for the program loader
module tb_tt_um_jleugeri_ticktocktokens_progloader;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  prog_header;
  logic [7:0]  prog_data;
  logic        prog_strobe;
  logic        wr_ready;

  logic        v1, e1, v2, e2;
  logic [3:0]  f1, f2;
  logic [7:0]  a1, a2;
  logic [15:0] d1, d2;

  int pass_cnt = 0;
  int total_cnt = 0;

  int         hs1 = 0;
  logic [3:0] l1_field;
  logic [7:0] l1_addr;
  logic [15:0] l1_data;
  logic [7:0] l2_addrs[$];

  always #5 clk = ~clk;

  tt_um_jleugeri_ticktocktokens_progloader dut (
    .clock_fast(clk), .reset(reset), .prog_header(prog_header), .prog_data(prog_data),
    .prog_strobe(prog_strobe), .wr_valid(v1), .wr_ready(wr_ready), .wr_field(f1),
    .wr_addr(a1), .wr_data(d1), .prog_error(e1)
  );

  tt_um_jleugeri_ticktocktokens_progloader #(.NUM_PROCESSORS(256)) dut_wide (
    .clock_fast(clk), .reset(reset), .prog_header(prog_header), .prog_data(prog_data),
    .prog_strobe(prog_strobe), .wr_valid(v2), .wr_ready(wr_ready), .wr_field(f2),
    .wr_addr(a2), .wr_data(d2), .prog_error(e2)
  );

  always @(posedge clk) begin
    if (v1 && wr_ready) begin
      hs1++;
      l1_field = f1;
      l1_addr  = a1;
      l1_data  = d1;
    end
    if (v2 && wr_ready) l2_addrs.push_back(a2);
  end

  typedef struct {
    logic [3:0]  hdr;
    logic [7:0]  data;
    logic [7:0]  addr;
    int          n_wr;
    logic [15:0] exp_data;
    logic        exp_err;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic send(input logic [3:0] h, input logic [7:0] d);
    prog_header = h;
    prog_data   = d;
    prog_strobe = 1'b1;
    @(posedge clk); #1;
    prog_strobe = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int h;
    int h2;
    logic [7:0] exp_inc;

    vecs[0] = '{4'h2, 8'h5A, 8'h03, 1, 16'h005A, 1'b0};
    vecs[1] = '{4'h3, 8'hA5, 8'h09, 1, 16'h00A5, 1'b0};
    vecs[2] = '{4'h4, 8'hFF, 8'h00, 1, 16'h00FF, 1'b0};
    vecs[3] = '{4'h5, 8'h11, 8'd49, 1, 16'h0011, 1'b0};
    vecs[4] = '{4'h6, 8'h22, 8'd50, 0, 16'h0000, 1'b1};
    vecs[5] = '{4'h3, 8'h00, 8'h0A, 0, 16'h0000, 1'b1};
    vecs[6] = '{4'h0, 8'h77, 8'h02, 0, 16'h0000, 1'b0};
    vecs[7] = '{4'h7, 8'h01, 8'h00, 0, 16'h0000, 1'b1};
    vecs[8] = '{4'hE, 8'h01, 8'h00, 0, 16'h0000, 1'b1};
    vecs[9] = '{4'h6, 8'h80, 8'h00, 1, 16'h0080, 1'b0};

    // Strobe held high through reset release must not count as a byte.
    reset = 1'b1; prog_strobe = 1'b1; prog_header = 4'h7; prog_data = 8'h00; wr_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    idle(3);
    check("reset_error", {31'd0, e1}, 32'd0);
    check("reset_valid", {31'd0, v1}, 32'd0);
    check("reset_field", {28'd0, f1}, 32'd0);
    check("reset_addr", {24'd0, a1}, 32'd0);
    check("reset_data", {16'd0, d1}, 32'd0);
    prog_strobe = 1'b0;
    idle(1);
    prog_strobe = 1'b1;
    idle(1);
    check("strobe_reedge_error", {31'd0, e1}, 32'd1);
    prog_strobe = 1'b0;
    idle(1);
    wr_ready = 1'b1;
    send(4'hF, 8'h00);
    check("abort_clears_error", {31'd0, e1}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      send(4'hF, 8'h00);
      send(4'h1, vecs[i].addr);
      h = hs1;
      send(vecs[i].hdr, vecs[i].data);
      idle(2);
      check($sformatf("vec%0d_writes", i), 32'(hs1 - h), 32'(vecs[i].n_wr));
      check($sformatf("vec%0d_error", i), {31'd0, e1}, {31'd0, vecs[i].exp_err});
      if (vecs[i].n_wr == 1) begin
        check($sformatf("vec%0d_field", i), {28'd0, l1_field}, {28'd0, vecs[i].hdr});
        check($sformatf("vec%0d_addr", i), {24'd0, l1_addr}, {24'd0, vecs[i].addr});
        check($sformatf("vec%0d_data", i), {16'd0, l1_data}, {16'd0, vecs[i].exp_data});
      end
    end

    // Single-byte write: valid exactly one cycle, one cycle after acceptance.
    send(4'hF, 8'h00);
    send(4'h1, 8'h03);
    h = hs1;
    prog_header = 4'h2; prog_data = 8'h5A; prog_strobe = 1'b1;
    idle(1);
    prog_strobe = 1'b0;
    check("w1_out_cycle1", {3'd0, v1, f1, a1, d1}, {3'd0, 1'b1, 4'h2, 8'h03, 16'h005A});
    idle(1);
    check("w1_valid_cycle2", {31'd0, v1}, 32'd0);
    check("w1_handshakes", 32'(hs1 - h), 32'd1);

    // Duration pair.
    send(4'hF, 8'h00);
    send(4'h1, 8'h00);
    h = hs1;
    send(4'h8, 8'h34);
    check("dur_no_valid_after_lo", {31'd0, v1}, 32'd0);
    idle(2);
    check("dur_still_idle", {31'd0, v1}, 32'd0);
    send(4'h8, 8'h12);
    idle(2);
    check("dur_writes", 32'(hs1 - h), 32'd1);
    check("dur_out", {4'd0, l1_field, l1_addr, l1_data}, {4'd0, 4'h8, 8'h00, 16'h1234});
    check("dur_error", {31'd0, e1}, 32'd0);

    // Interrupted duration pair: error, then the interrupting byte still executes.
    send(4'hF, 8'h00);
    send(4'h1, 8'h00);
    send(4'h8, 8'h34);
    h = hs1;
    send(4'h2, 8'h5A);
    idle(2);
    check("dur_int_error", {31'd0, e1}, 32'd1);
    check("dur_int_writes", 32'(hs1 - h), 32'd1);
    check("dur_int_out", {4'd0, l1_field, l1_addr, l1_data}, {4'd0, 4'h2, 8'h00, 16'h005A});

    // Out of range then ABORT resets address.
    send(4'hF, 8'h00);
    send(4'h1, 8'h0A);
    h = hs1;
    send(4'h3, 8'h00);
    check("range_error", {31'd0, e1}, 32'd1);
    check("range_no_write", 32'(hs1 - h), 32'd0);
    send(4'hF, 8'h00);
    check("range_abort_error", {31'd0, e1}, 32'd0);
    send(4'h2, 8'h11);
    idle(2);
    check("abort_addr_zero", {31'd0, 1'b0}, {31'd0, 1'b0} | 32'(hs1 - h - 1));
    check("abort_addr_value", {24'd0, l1_addr}, 32'd0);

    // Backpressure with a byte arriving mid-stall.
    wr_ready = 1'b0;
    send(4'hF, 8'h00);
    send(4'h1, 8'h01);
    h = hs1;
    prog_header = 4'h5; prog_data = 8'h33; prog_strobe = 1'b1;
    idle(1);
    prog_strobe = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check($sformatf("stall_c%0d", c), {3'd0, v1, f1, a1, d1}, {3'd0, 1'b1, 4'h5, 8'h01, 16'h0033});
      if (c == 2) begin
        prog_header = 4'h2; prog_data = 8'h99; prog_strobe = 1'b1;
      end else begin
        prog_strobe = 1'b0;
      end
      idle(1);
    end
    prog_strobe = 1'b0;
    check("stall_error", {31'd0, e1}, 32'd1);
    wr_ready = 1'b1;
    idle(1);
    check("stall_release_valid", {31'd0, v1}, 32'd0);
    idle(2);
    check("stall_handshakes", 32'(hs1 - h), 32'd1);
    check("stall_out", {4'd0, l1_field, l1_addr, l1_data}, {4'd0, 4'h5, 8'h01, 16'h0033});

    // Auto-increment on the wide instance.
    send(4'hF, 8'h00);
    send(4'h1, 8'hFF);
    h2 = l2_addrs.size();
    send(4'h2, 8'h01);
    send(4'h2, 8'h02);
    idle(2);
`ifdef PROGLOADER_AUTOINC_EN
    exp_inc = 8'h00;
`else
    exp_inc = 8'hFF;
`endif
    check("inc_writes", 32'(l2_addrs.size() - h2), 32'd2);
    if (l2_addrs.size() >= h2 + 2) begin
      check("inc_addr_first", {24'd0, l2_addrs[h2]}, 32'h000000FF);
      check("inc_addr_second", {24'd0, l2_addrs[h2+1]}, {24'd0, exp_inc});
    end

    // Reset while a write is pending.
    wr_ready = 1'b0;
    send(4'hF, 8'h00);
    send(4'h1, 8'h02);
    h = hs1;
    prog_header = 4'h2; prog_data = 8'h44; prog_strobe = 1'b1;
    idle(1);
    prog_strobe = 1'b0;
    check("emit_pre_reset_valid", {31'd0, v1}, 32'd1);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    check("emit_post_reset_valid", {31'd0, v1}, 32'd0);
    wr_ready = 1'b1;
    idle(2);
    check("emit_reset_no_write", 32'(hs1 - h), 32'd0);

    // Reset while waiting for a duration high byte.
    send(4'h1, 8'h00);
    send(4'h8, 8'h34);
    do_reset();
    h = hs1;
    send(4'h8, 8'h12);
    idle(2);
    check("waithi_reset_no_write", 32'(hs1 - h), 32'd0);
    check("waithi_reset_valid", {31'd0, v1}, 32'd0);
    send(4'hF, 8'h00);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
